// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// MEM/WB pipeline register and writeback logic for a 5-stage RV32I core.
// The block captures the memory-stage result bundle, formats load data
// (byte/half/word, sign or zero extension), selects the writeback value and
// drives the register-file write port. It also presents a forwarding bundle
// for the execute-stage bypass mux and keeps a 64-bit retired-instruction
// counter.
//
// Parameters
//   XLEN          datapath width (load formatting assumes 32)
//   RA_W          register address width
//   RETIRE_RESET  value loaded into retire_count on reset (normally 0)
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid          memory stage holds a valid instruction
//   stall             hold WB contents (no new capture)
//   flush             kill the instruction being captured
//   in_rd             destination register
//   in_reg_write      instruction writes rd
//   in_is_load        instruction is a load
//   in_result_src     00 ALU, 01 load data, 10 PC+4, 11 reserved (zero)
//   in_funct3         load size/sign code
//   in_alu_result     ALU result, also the load address
//   in_read_data      raw word-aligned word from data memory
//   in_pc_plus4       link value
//   rf_we/addr/wdata  register file write port (WE3/A3/WD3)
//   fwd_valid/rd/data forwarding bundle for the execute-stage bypass
//   load_fault        misaligned or illegal load currently held in WB
//   retire_count      retired-instruction counter
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int          XLEN         = 32,
    parameter int          RA_W         = 5,
    parameter logic [63:0] RETIRE_RESET = 64'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [1:0]      in_result_src,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [XLEN-1:0] in_pc_plus4,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [RA_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_fault,
    output logic [63:0]     retire_count
);

    // Load size/sign codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback source select
    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic            r_wb_valid;    // WB holds a live instruction
    logic            r_wb_fresh;    // first cycle of that instruction in WB
    logic [RA_W-1:0] r_rd;
    logic            r_reg_write;
    logic            r_is_load;
    logic [1:0]      r_result_src;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_read_data;
    logic [XLEN-1:0] r_pc_plus4;
    logic [63:0]     r_retire_count;

    // -------------------------------------------------------------------------
    // Combinational writeback path
    // -------------------------------------------------------------------------
    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_fault_cond;
    logic            w_load_fault;
    logic            w_commit;
    logic [XLEN-1:0] w_wb_value;

    assign w_off  = r_alu_result[1:0];
    // Memory returns a whole aligned word; pick the addressed lane.
    assign w_byte = r_read_data[{w_off, 3'b000} +: 8];
    assign w_half = r_read_data[{w_off[1], 4'b0000} +: 16];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case statement can leave it unassigned (no latch).
    always_comb begin
        w_load_data  = '0;
        w_fault_cond = 1'b0;
        case (r_funct3)
            F3_LB: begin
                w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            end
            F3_LBU: begin
                w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            end
            F3_LH: begin
                w_load_data  = {{(XLEN-16){w_half[15]}}, w_half};
                w_fault_cond = w_off[0];
            end
            F3_LHU: begin
                w_load_data  = {{(XLEN-16){1'b0}}, w_half};
                w_fault_cond = w_off[0];
            end
            F3_LW: begin
                w_load_data  = r_read_data;
                w_fault_cond = (w_off != 2'b00);
            end
            default: begin
                // 011, 110, 111 are not RV32I loads.
                w_fault_cond = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_wb_value = '0;
        case (r_result_src)
            SRC_ALU:  w_wb_value = r_alu_result;
            SRC_LOAD: w_wb_value = w_load_data;
            SRC_PC4:  w_wb_value = r_pc_plus4;
            default:  w_wb_value = '0;
        endcase
    end

    // The fault is qualified by is_load only; a non-load instruction never
    // faults regardless of what its funct3 field happens to hold.
    assign w_load_fault = r_wb_valid & r_is_load & w_fault_cond;

    // x0 writes and faulting loads never reach the register file or bypass.
    assign w_commit = r_wb_valid & r_reg_write & (r_rd != '0) & ~w_load_fault;

    // -------------------------------------------------------------------------
    // Control state and retire counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_fresh     <= 1'b0;
            r_retire_count <= RETIRE_RESET;
        end else begin
            // The instruction leaving its first WB cycle retires on this edge,
            // whatever happens to the one being captured behind it.
            if (r_wb_fresh && !w_load_fault) begin
                r_retire_count <= r_retire_count + 64'd1;
            end

            if (flush) begin
                r_wb_valid <= 1'b0;
                r_wb_fresh <= 1'b0;
            end else if (stall) begin
                // Keep the occupant but drop fresh: exactly one RF write.
                r_wb_fresh <= 1'b0;
            end else begin
                r_wb_valid <= in_valid;
                r_wb_fresh <= in_valid;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Captured bundle
    // -------------------------------------------------------------------------
    // Cleared on reset so rf_addr/rf_wdata/fwd_* read as zero until the first
    // capture. On flush the bundle is irrelevant and simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_is_load    <= 1'b0;
            r_result_src <= 2'b00;
            r_funct3     <= 3'b000;
            r_alu_result <= '0;
            r_read_data  <= '0;
            r_pc_plus4   <= '0;
        end else if (!flush && !stall) begin
            r_rd         <= in_rd;
            r_reg_write  <= in_reg_write;
            r_is_load    <= in_is_load;
            r_result_src <= in_result_src;
            r_funct3     <= in_funct3;
            r_alu_result <= in_alu_result;
            r_read_data  <= in_read_data;
            r_pc_plus4   <= in_pc_plus4;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rf_we        = w_commit & r_wb_fresh;
    assign rf_addr      = r_rd;
    assign rf_wdata     = w_wb_value;
    assign fwd_valid    = w_commit;
    assign fwd_rd       = r_rd;
    assign fwd_data     = w_wb_value;
    assign load_fault   = w_load_fault;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Self-checking bench for writeback_stage: reset behaviour, a table of
// directed load/ALU/PC+4 vectors, stall/flush sequences and a randomized run
// against a behavioural model. A second instance preset to 2^64-1 shares all
// inputs and shows the retire counter wrapping.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic [1:0]  in_result_src = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_read_data = '0;
    logic [31:0] in_pc_plus4 = '0;

    logic        rf_we, fwd_valid, load_fault;
    logic [4:0]  rf_addr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data;
    logic [63:0] retire_count;

    logic        w_rf_we, w_fwd_valid, w_load_fault;
    logic [4:0]  w_rf_addr, w_fwd_rd;
    logic [31:0] w_rf_wdata, w_fwd_data;
    logic [63:0] w_retire_count;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_result_src(in_result_src), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_read_data(in_read_data),
        .in_pc_plus4(in_pc_plus4),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_fault(load_fault), .retire_count(retire_count)
    );

    writeback_stage #(.RETIRE_RESET(ALL_ONES)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_result_src(in_result_src), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_read_data(in_read_data),
        .in_pc_plus4(in_pc_plus4),
        .rf_we(w_rf_we), .rf_addr(w_rf_addr), .rf_wdata(w_rf_wdata),
        .fwd_valid(w_fwd_valid), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
        .load_fault(w_load_fault), .retire_count(w_retire_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Sample one clock edge later, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Behavioural reference: load formatting and fault rules by arithmetic
    // -------------------------------------------------------------------------
    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
    } instr_t;

    function automatic bit ref_fault(input logic [2:0] f3, input int off);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (off % 2) != 0;
            3'd2:       return off != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        longint b, h;
        b = (longint'(w) >> (8 * off)) % 256;
        h = (longint'(w) >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0: return 32'(b >= 128 ? b - 256 : b);
            3'd4: return 32'(b);
            3'd1: return 32'(h >= 32768 ? h - 65536 : h);
            3'd5: return 32'(h);
            3'd2: return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_value(input instr_t i);
        case (i.src)
            2'd0:    return i.alu;
            2'd1:    return ref_load(i.f3, int'(i.alu % 4), i.rdata);
            2'd2:    return i.pc4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input instr_t i);
        in_valid      = i.valid;
        in_rd         = i.rd;
        in_reg_write  = i.rw;
        in_is_load    = i.ld;
        in_result_src = i.src;
        in_funct3     = i.f3;
        in_alu_result = i.alu;
        in_read_data  = i.rdata;
        in_pc_plus4   = i.pc4;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        instr_t      i;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        exp_fwd;
        logic        exp_fault;
    } vec_t;

    localparam logic [31:0] D = 32'h80FF_7F01;
    vec_t vecs[18];

    function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                                input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [31:0] wd, input logic we,
                                input logic fw, input logic flt);
        vec_t r;
        r.i.valid = v;  r.i.rd = rd;  r.i.rw = rw;  r.i.ld = ld;  r.i.src = src;
        r.i.f3 = f3;  r.i.alu = alu;  r.i.rdata = D;  r.i.pc4 = pc4;
        r.exp_wdata = wd;  r.exp_we = we;  r.exp_fwd = fw;  r.exp_fault = flt;
        return r;
    endfunction

    // Random-phase model state
    instr_t cur;
    bit     occ;
    int     age;
    logic [63:0] exp_cnt;

    initial begin
        instr_t idle, jal, nx;
        bit     prev_retire;
        int     we_pulses, fv_cycles;
        bit     f, commit;

        idle = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, src: 2'd0, f3: 3'd0,
                 alu: 32'd0, rdata: 32'd0, pc4: 32'd0};

        //            v  rd  rw ld src f3   alu           pc4     wdata           we fw flt
        vecs[0]  = mk(1, 5,  1, 0, 0, 3'd0, 32'h0000_1234, 32'h200, 32'h0000_1234, 1, 1, 0);
        vecs[1]  = mk(1, 6,  1, 1, 1, 3'd0, 32'h0000_1002, 32'h200, 32'hFFFF_FFFF, 1, 1, 0);
        vecs[2]  = mk(1, 7,  1, 1, 1, 3'd4, 32'h0000_1003, 32'h200, 32'h0000_0080, 1, 1, 0);
        vecs[3]  = mk(1, 8,  1, 1, 1, 3'd1, 32'h0000_1000, 32'h200, 32'h0000_7F01, 1, 1, 0);
        vecs[4]  = mk(1, 9,  1, 1, 1, 3'd5, 32'h0000_1002, 32'h200, 32'h0000_80FF, 1, 1, 0);
        vecs[5]  = mk(1, 10, 1, 1, 1, 3'd2, 32'h0000_1000, 32'h200, 32'h80FF_7F01, 1, 1, 0);
        vecs[6]  = mk(1, 11, 1, 1, 1, 3'd2, 32'h0000_1002, 32'h200, 32'h0,         0, 0, 1);
        vecs[7]  = mk(1, 12, 1, 1, 1, 3'd3, 32'h0000_1000, 32'h200, 32'h0,         0, 0, 1);
        vecs[8]  = mk(1, 13, 1, 1, 1, 3'd0, 32'h0000_1001, 32'h200, 32'h0000_007F, 1, 1, 0);
        vecs[9]  = mk(1, 14, 1, 1, 1, 3'd1, 32'h0000_1002, 32'h200, 32'hFFFF_80FF, 1, 1, 0);
        vecs[10] = mk(1, 15, 1, 1, 1, 3'd1, 32'h0000_1001, 32'h200, 32'h0,         0, 0, 1);
        vecs[11] = mk(1, 16, 1, 1, 1, 3'd5, 32'h0000_1003, 32'h200, 32'h0,         0, 0, 1);
        vecs[12] = mk(1, 1,  1, 0, 2, 3'd0, 32'h0000_0044, 32'h104, 32'h0000_0104, 1, 1, 0);
        vecs[13] = mk(1, 17, 1, 0, 3, 3'd0, 32'h0000_0055, 32'h200, 32'h0,         1, 1, 0);
        vecs[14] = mk(1, 0,  1, 0, 0, 3'd0, 32'h0000_0066, 32'h200, 32'h0,         0, 0, 0);
        vecs[15] = mk(1, 18, 0, 0, 0, 3'd0, 32'h0000_0077, 32'h200, 32'h0,         0, 0, 0);
        vecs[16] = mk(0, 19, 1, 1, 1, 3'd3, 32'h0000_1002, 32'h200, 32'h0,         0, 0, 0);
        vecs[17] = mk(1, 20, 1, 1, 1, 3'd0, 32'h0000_1000, 32'h200, 32'h0000_0001, 1, 1, 0);

        // ---------------- Reset: all outputs zero while rst is high ----------
        drive(idle);
        repeat (2) tick();
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_fwd_data", 64'(fwd_data), 64'd0);
        check("rst_load_fault", 64'(load_fault), 64'd0);
        check("rst_retire", retire_count, 64'd0);
        check("rst_wrap_preset", w_retire_count, ALL_ONES);
        #3 rst = 1'b0;
        tick();

        // ---------------- Async reset in the middle of a write ---------------
        drive(vecs[0].i);
        tick();
        check("arst_pre_we", 64'(rf_we), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_rf_we", 64'(rf_we), 64'd0);
        check("arst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("arst_rf_addr", 64'(rf_addr), 64'd0);
        check("arst_rf_wdata", 64'(rf_wdata), 64'd0);
        drive(idle);
        #2 rst = 1'b0;
        tick();
        check("arst_retire_after", retire_count, 64'd0);
        check("arst_rf_we_after", 64'(rf_we), 64'd0);

        // ---------------- Directed table ------------------------------------
        exp_cnt     = 64'd0;
        prev_retire = 1'b0;
        foreach (vecs[k]) begin
            drive(vecs[k].i);
            tick();
            if (prev_retire) exp_cnt = exp_cnt + 64'd1;
            check($sformatf("vec%0d_rf_we", k), 64'(rf_we), 64'(vecs[k].exp_we));
            check($sformatf("vec%0d_fwd_valid", k), 64'(fwd_valid), 64'(vecs[k].exp_fwd));
            check($sformatf("vec%0d_fault", k), 64'(load_fault), 64'(vecs[k].exp_fault));
            if (vecs[k].exp_fwd) begin
                check($sformatf("vec%0d_rf_addr", k), 64'(rf_addr), 64'(vecs[k].i.rd));
                check($sformatf("vec%0d_rf_wdata", k), 64'(rf_wdata), 64'(vecs[k].exp_wdata));
                check($sformatf("vec%0d_fwd_rd", k), 64'(fwd_rd), 64'(vecs[k].i.rd));
                check($sformatf("vec%0d_fwd_data", k), 64'(fwd_data), 64'(vecs[k].exp_wdata));
            end
            check($sformatf("vec%0d_retire", k), retire_count, exp_cnt);
            check($sformatf("vec%0d_wrap_retire", k), w_retire_count, ALL_ONES + exp_cnt);
            prev_retire = vecs[k].i.valid && !vecs[k].exp_fault;
        end
        drive(idle);
        tick();
        if (prev_retire) exp_cnt = exp_cnt + 64'd1;
        check("table_retire_final", retire_count, exp_cnt);
        check("table_wrap_final", w_retire_count, ALL_ONES + exp_cnt);

        // ---------------- JAL held by a 3-cycle stall ------------------------
        jal = '{valid: 1'b1, rd: 5'd1, rw: 1'b1, ld: 1'b0, src: 2'd2, f3: 3'd0,
                alu: 32'hDEAD_0000, rdata: 32'h0, pc4: 32'h0000_0104};
        we_pulses = 0;
        fv_cycles = 0;
        drive(jal);
        tick();
        we_pulses += int'(rf_we);
        fv_cycles += int'(fwd_valid);
        check("jal_fwd_data", 64'(fwd_data), 64'h104);
        // Different inputs during the stall must not disturb the held bundle.
        nx = jal;
        nx.rd = 5'd7;
        nx.pc4 = 32'h0000_0999;
        drive(nx);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            we_pulses += int'(rf_we);
            fv_cycles += int'(fwd_valid);
            check($sformatf("stall%0d_fwd_rd", c), 64'(fwd_rd), 64'd1);
            check($sformatf("stall%0d_fwd_data", c), 64'(fwd_data), 64'h104);
        end
        exp_cnt = exp_cnt + 64'd1;
        check("stall_we_pulses", 64'(we_pulses), 64'd1);
        check("stall_fwd_cycles", 64'(fv_cycles), 64'd4);
        check("stall_retire", retire_count, exp_cnt);
        flush = 1'b1;
        tick();
        check("flush_stall_fwd_valid", 64'(fwd_valid), 64'd0);
        check("flush_stall_rf_we", 64'(rf_we), 64'd0);
        check("flush_stall_retire", retire_count, exp_cnt);
        flush = 1'b0;
        stall = 1'b0;
        drive(idle);
        tick();
        check("idle_retire", retire_count, exp_cnt);

        // ---------------- Randomized run against the model -------------------
        occ = 1'b0;
        age = 0;
        cur = idle;
        for (int n = 0; n < 600; n++) begin
            instr_t r;
            logic   r_stall, r_flush;
            r.valid = ($urandom_range(0, 9) < 8);
            r.rd    = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r.rw    = ($urandom_range(0, 7) != 0);
            r.ld    = $urandom_range(0, 1) == 1;
            r.src   = 2'($urandom_range(0, 3));
            r.f3    = 3'($urandom_range(0, 7));
            r.alu   = $urandom;
            r.rdata = $urandom;
            r.pc4   = $urandom;
            r_stall = ($urandom_range(0, 4) == 0);
            r_flush = ($urandom_range(0, 9) == 0);
            drive(r);
            stall = r_stall;
            flush = r_flush;
            tick();

            // Model the edge that just happened.
            if (occ && age == 0 && !(cur.ld && ref_fault(cur.f3, int'(cur.alu % 4))))
                exp_cnt = exp_cnt + 64'd1;
            if (r_flush) begin
                occ = 1'b0;
            end else if (r_stall) begin
                age++;
            end else begin
                cur = r;
                occ = r.valid;
                age = 0;
            end

            f      = occ && cur.ld && ref_fault(cur.f3, int'(cur.alu % 4));
            commit = occ && cur.rw && cur.rd != 0 && !f;
            check($sformatf("rnd%0d_fault", n), 64'(load_fault), 64'(f));
            check($sformatf("rnd%0d_fwd_valid", n), 64'(fwd_valid), 64'(commit));
            check($sformatf("rnd%0d_rf_we", n), 64'(rf_we), 64'(commit && age == 0));
            if (commit) begin
                check($sformatf("rnd%0d_rf_addr", n), 64'(rf_addr), 64'(cur.rd));
                check($sformatf("rnd%0d_rf_wdata", n), 64'(rf_wdata), 64'(ref_value(cur)));
                check($sformatf("rnd%0d_fwd_data", n), 64'(fwd_data), 64'(ref_value(cur)));
            end
            check($sformatf("rnd%0d_retire", n), retire_count, exp_cnt);
        end
        check("rnd_wrap_retire", w_retire_count, ALL_ONES + exp_cnt);

        stall = 1'b0;
        flush = 1'b0;
        drive(idle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and writeback logic for the 5-stage RV32I core. Captures the memory-stage result bundle, formats load data (byte/half/word, sign/zero extend), selects the writeback value, and drives the register file's write port (WE3/A3/WD3). Also provides a forwarding bundle for the execute-stage bypass mux and a 64-bit retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  memory stage holds a valid instruction
- stall  input  1  hold WB register contents
- flush  input  1  kill the instruction being captured
- in_rd  input  RA_W  destination register
- in_reg_write  input  1  instruction writes rd
- in_is_load  input  1  instruction is a load
- in_result_src  input  2  00 ALU, 01 load data, 10 PC+4, 11 reserved
- in_funct3  input  3  load size/sign code
- in_alu_result  input  XLEN  ALU result, also the load address
- in_read_data  input  XLEN  raw word from data memory, word-aligned
- in_pc_plus4  input  XLEN  link value
- rf_we  output  1  to register file WE3
- rf_addr  output  RA_W  to register file A3
- rf_wdata  output  XLEN  to register file WD3
- fwd_valid  output  1  forwarding bundle valid
- fwd_rd  output  RA_W  forwarding destination
- fwd_data  output  XLEN  forwarding value (equals rf_wdata)
- load_fault  output  1  misaligned or illegal load held in WB
- retire_count  output  64  retired-instruction counter

## Operation
- State: wb_valid, wb_fresh, the captured bundle, and retire_count.
- Capture edge, priority order: flush -> wb_valid=0 and wb_fresh=0, bundle don't-care. Else stall -> hold everything and clear wb_fresh. Else -> load bundle, wb_valid=in_valid, wb_fresh=in_valid.
- wb_fresh is high only in the first cycle an instruction occupies WB. This guarantees exactly one register-file write per instruction under stall.
- Load formatting uses off = wb_alu_result[1:0]:
  - funct3 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: half at off[1], sign-extended; fault if off[0]=1.
  - 101 LHU: as LH, zero-extended; same fault rule.
  - 010 LW: full word; fault if off!=0.
  - 011/110/111: illegal, fault.
- load_fault = wb_valid & wb_is_load & fault condition.
- Writeback value by result_src:
  - 00: ALU result.
  - 01: formatted load data.
  - 10: PC+4.
  - 11: 0.
- commit = wb_valid & wb_reg_write & (wb_rd!=0) & ~load_fault.
- rf_we = commit & wb_fresh. rf_addr = wb_rd. rf_wdata = selected value.
- fwd_valid = commit, asserted for the whole occupancy including stall cycles. fwd_rd = wb_rd. fwd_data = rf_wdata.
- retire_count increments by 1 on each edge where wb_fresh=1 and load_fault=0. Faulting instructions are not counted. The counter wraps from 2^64-1 to 0.

## Timing
- Reset (async, immediate): wb_valid=0, wb_fresh=0, retire_count=0. Every output is 0 while rst is high and after release until the first capture.
- Latency: bundle captured at edge N. rf_we, fwd_* and load_fault are valid combinationally during cycle N. The register write lands at edge N+1.
- Stall in cycle N+1 after capture at N: rf_we=0 and fwd_valid stays 1 with the same data. No second write and no second count.
- flush and stall together: flush wins, and WB becomes empty.
- Reset asserted mid-stall or mid-write: state clears immediately and no write is issued.
- Writes to x0 never assert rf_we or fwd_valid, but the instruction is still counted.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 at once; retire_count=0 after release.
- ALU writeback: capture rd=5, src=00, alu=0x0000_1234 -> next cycle rf_we=1, rf_addr=5, rf_wdata=0x1234; retire_count=1.
- Loads with read_data=0x80FF_7F01:
  - LB off=2 -> 0xFFFF_FFFF.
  - LBU off=3 -> 0x0000_0080.
  - LH off=0 -> 0x0000_7F01.
  - LHU off=2 -> 0x0000_80FF.
  - LW off=0 -> 0x80FF_7F01.
- Fault: LW off=2 -> load_fault=1, rf_we=0, fwd_valid=0, retire_count unchanged. funct3=011 -> same response.
- Stall and flush: capture JAL rd=1 with pc_plus4=0x104, then stall 3 cycles -> exactly one rf_we pulse, fwd_valid=1 for 4 cycles, count +1. Then flush+stall together -> wb_valid=0.
- x0 and wrap: rd=0 write -> rf_we=0 but count increments. Counter preset to 2^64-1 via one retire -> wraps to 0.
